// File: rtl/meas_pkg.sv
// Shared definitions for the measurement-window sequencer: FSM state
// encodings and default widths.
package meas_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // Default widths
    localparam int DIV_W_DEF = 32;
    localparam int WIN_W_DEF = 16;
    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/meas_tick_gen.sv
// Runtime-loadable tick divider. Counts 0..div and pulses tick for one
// cycle when the count equals div, then wraps. div==0 ticks every cycle.
// clr holds the counter at zero (used while no measurement is running).
module meas_tick_gen
    import meas_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Tick on terminal count; next count wraps or is cleared
    always_comb begin
        tick  = (cnt_q == div);
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Divider count register
    always_ff @(posedge inclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/meas_window_ctrl.sv
// Measurement sequencer: accepts a (divisor, window) command, counts
// synchronised rising edges of evt_in over exactly (div+1)*win cycles and
// returns the count over a valid/ready result handshake.
// Build option: define MEAS_SAT_EN to make the event counter saturate at
// its maximum on overflow; otherwise it wraps to zero. res_ovf is set in
// both cases.
module meas_window_ctrl
    import meas_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [WIN_W-1:0] cmd_win,
    input  logic             cmd_abort,
    input  logic             evt_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_ovf
);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_ovf_q, res_ovf_d;
    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;

    logic             tick;
    logic             tick_clr;
    logic             evt_edge;
    logic [CNT_W-1:0] cnt_step;
    logic             ovf_step;

    // Divider only runs during RUN; ARM (and every other state) holds it at 0
    assign tick_clr = (state_q != ST_RUN);

    meas_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .inclk (inclk),
        .reset (reset),
        .clr   (tick_clr),
        .div   (div_q),
        .tick  (tick)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_REPORT);
    assign res_count = res_count_q;
    assign res_ovf   = res_ovf_q;

    // Synchroniser and edge detector; prev follows sync every cycle, so in
    // ARM it captures the current level and a line already high is not counted
    always_comb begin
        sync_d   = {sync_q[0], evt_in};
        prev_d   = sync_q[1];
        evt_edge = sync_q[1] & ~prev_q;
    end

    // Event count after this cycle's edge, including overflow handling
    always_comb begin
        cnt_step = evt_cnt_q;
        ovf_step = ovf_q;
        if (evt_edge) begin
            if (evt_cnt_q == {CNT_W{1'b1}}) begin
                ovf_step = 1'b1;
`ifdef MEAS_SAT_EN
                cnt_step = evt_cnt_q;
`else
                cnt_step = '0;
`endif
            end else begin
                cnt_step = evt_cnt_q + CNT_W'(1);
            end
        end
    end

    // Sequencer FSM: window timing, counting and result latching
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        win_d       = win_q;
        tick_cnt_d  = tick_cnt_q;
        evt_cnt_d   = evt_cnt_q;
        ovf_d       = ovf_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    div_d     = cmd_div;
                    win_d     = cmd_win;
                    evt_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                tick_cnt_d = '0;
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else if (win_q == '0) begin
                    res_count_d = '0;
                    res_ovf_d   = 1'b0;
                    state_d     = ST_REPORT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a tick landing in the same cycle
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    evt_cnt_d = cnt_step;
                    ovf_d     = ovf_step;
                    if (tick) begin
                        if (tick_cnt_q == win_q - WIN_W'(1)) begin
                            // Final tick: result includes an edge on this cycle
                            res_count_d = cnt_step;
                            res_ovf_d   = ovf_step;
                            state_d     = ST_REPORT;
                        end else begin
                            tick_cnt_d = tick_cnt_q + WIN_W'(1);
                        end
                    end
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, configuration, counter and result registers
    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            win_q       <= '0;
            tick_cnt_q  <= '0;
            evt_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
            sync_q      <= '0;
            prev_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            win_q       <= win_d;
            tick_cnt_q  <= tick_cnt_d;
            evt_cnt_q   <= evt_cnt_d;
            ovf_q       <= ovf_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
        end
    end

endmodule
